// File: rtl/sevenseg_scan_ctrl_if.sv
// Display bus between a digit source and the seven-segment scan controller.
// Inputs are digit values, DP requests and enable; outputs are the board-level active-low lines.
interface sevenseg_scan_ctrl_if;
    logic [3:0] Digit0;
    logic [3:0] Digit1;
    logic [3:0] Digit2;
    logic [3:0] Digit3;
    logic [3:0] DP_in;
    logic       Enable;
    logic [6:0] Seg;
    logic       DP;
    logic [3:0] Anode;
    logic       Scan_tick;

    modport master (
        output Digit0, Digit1, Digit2, Digit3, DP_in, Enable,
        input  Seg, DP, Anode, Scan_tick
    );

    modport slave (
        input  Digit0, Digit1, Digit2, Digit3, DP_in, Enable,
        output Seg, DP, Anode, Scan_tick
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// 4-digit common-anode seven-segment scanner; outputs registered, 1 cycle behind sel, no backpressure.
// Optional leading-zero blanking under `define LEADING_ZERO_BLANK_EN.
module sevenseg_scan_ctrl #(
    parameter int REFRESH_CNT = 100000,
    parameter int REFRESH_W   = 17
) (
    input  logic                 CLK,
    input  logic                 Reset,
    sevenseg_scan_ctrl_if.slave  bus
);

    logic [REFRESH_W-1:0] cnt;
    logic [1:0]           sel;
    logic                 sel_chg;
    logic                 cnt_wrap;
    logic [3:0]           cur_digit;
    logic [6:0]           cur_seg;
    logic [3:0]           sel_onehot;
    logic [3:0]           blank;
    logic                 cur_blank;

    logic [3:0]           anode_q;
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic                 tick_q;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign cnt_wrap = (cnt == REFRESH_W'(REFRESH_CNT - 1));

    always_comb begin
        cur_digit = bus.Digit0;
        case (sel)
            2'd0: cur_digit = bus.Digit0;
            2'd1: cur_digit = bus.Digit1;
            2'd2: cur_digit = bus.Digit2;
            2'd3: cur_digit = bus.Digit3;
            default: cur_digit = bus.Digit0;
        endcase
    end

    assign cur_seg    = decode(cur_digit);
    assign sel_onehot = 4'b0001 << sel;

    // A digit is a leading zero only if it and every digit to its left are zero.
`ifdef LEADING_ZERO_BLANK_EN
    assign blank[3] = (bus.Digit3 == 4'd0);
    assign blank[2] = blank[3] && (bus.Digit2 == 4'd0);
    assign blank[1] = blank[2] && (bus.Digit1 == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    assign cur_blank = blank[sel];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt     <= '0;
            sel     <= 2'd0;
            sel_chg <= 1'b0;
            anode_q <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            if (cnt_wrap) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + REFRESH_W'(1);
            end
            // sel_chg delays the wrap so the tick lines up with the first cycle of the new anode.
            sel_chg <= cnt_wrap;
            tick_q  <= sel_chg;
            anode_q <= (bus.Enable && !cur_blank) ? ~sel_onehot : 4'b1111;
            seg_q   <= cur_seg;
            dp_q    <= cur_blank | ~bus.DP_in[sel];
        end
    end

    assign bus.Anode     = anode_q;
    assign bus.Seg       = seg_q;
    assign bus.DP        = dp_q;
    assign bus.Scan_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with REFRESH_CNT=4; expectations come from the decode table
// and the scan schedule (edge k after reset shows digit ((k-1)/4)%4).
module tb_sevenseg_scan_ctrl;

    logic CLK;
    logic Reset;
    int   k;
    int   total;
    int   passed;
    int   failed;

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sevenseg_scan_ctrl_if bus();

    sevenseg_scan_ctrl #(.REFRESH_CNT(4), .REFRESH_W(3)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".anode"}, {4'h0, bus.Anode}, 8'h0F);
        check({tag, ".seg"},   {1'b0, bus.Seg},   8'h7F);
        check({tag, ".dp"},    {7'h0, bus.DP},    8'h01);
        check({tag, ".tick"},  {7'h0, bus.Scan_tick}, 8'h00);
    endtask

    // One clock edge with all four outputs checked against the scan schedule and current inputs.
    task automatic run_edge(input string tag);
        int         idx;
        logic [3:0] d [4];
        logic       blank;
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        logic       etk;
        d[0] = bus.Digit0;
        d[1] = bus.Digit1;
        d[2] = bus.Digit2;
        d[3] = bus.Digit3;
        idx   = (k / 4) % 4;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            3: blank = (d[3] == 4'd0);
            2: blank = (d[3] == 4'd0) && (d[2] == 4'd0);
            1: blank = (d[3] == 4'd0) && (d[2] == 4'd0) && (d[1] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        ea  = (bus.Enable && !blank) ? ~(4'b0001 << idx) : 4'b1111;
        es  = dec_tbl[d[idx]];
        edp = blank | ~bus.DP_in[idx];
        tick();
        k++;
        etk = (k > 1) && ((k - 1) % 4 == 0);
        check({tag, ".anode"}, {4'h0, bus.Anode}, {4'h0, ea});
        check({tag, ".seg"},   {1'b0, bus.Seg},   {1'b0, es});
        check({tag, ".dp"},    {7'h0, bus.DP},    {7'h0, edp});
        check({tag, ".tick"},  {7'h0, bus.Scan_tick}, {7'h0, etk});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        k      = 0;
        Reset       = 1'b1;
        bus.Digit0  = 4'd1;
        bus.Digit1  = 4'd2;
        bus.Digit2  = 4'd3;
        bus.Digit3  = 4'd4;
        bus.DP_in   = 4'b0000;
        bus.Enable  = 1'b1;

        // 1: reset held three cycles, then the first edge shows digit 0
        for (int i = 0; i < 3; i++) tick();
        check_reset_vals("rst_hold");
        Reset = 1'b0;
        k = 0;
        tick();
        k++;
        check("first.anode", {4'h0, bus.Anode}, 8'h0E);
        check("first.seg",   {1'b0, bus.Seg},   8'h79);
        check("first.dp",    {7'h0, bus.DP},    8'h01);
        check("first.tick",  {7'h0, bus.Scan_tick}, 8'h00);

        // 2: full scan, each anode held four cycles, tick on every change
        for (int i = 0; i < 16; i++) run_edge("scan");
        check("scan_wrap.anode", {4'h0, bus.Anode}, 8'h0E);
        check("scan_wrap.tick",  {7'h0, bus.Scan_tick}, 8'h01);

        // 3: every Digit0 value while digit 0 is selected, DP only on digit 0
        bus.DP_in = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            while ((k / 4) % 4 != 0) run_edge("s3_wait");
            bus.Digit0 = 4'(v);
            run_edge("s3_dec");
        end
        while ((k / 4) % 4 != 1) run_edge("s3_dp");
        run_edge("s3_dp_d1");
        check("s3_dp_off", {7'h0, bus.DP}, 8'h01);

        // 4: display disabled mid-scan, scan keeps advancing
        bus.Digit0 = 4'd1;
        bus.DP_in  = 4'b0000;
        run_edge("s4_pre");
        bus.Enable = 1'b0;
        for (int i = 0; i < 10; i++) run_edge("s4_off");
        bus.Enable = 1'b1;
        run_edge("s4_on");

        // 5: reset with sel=2, cnt=2, then a fresh full dwell on digit 0
        while (k % 16 != 10) run_edge("s5_wait");
        Reset = 1'b1;
        tick();
        check_reset_vals("s5_rst");
        Reset = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) run_edge("s5_dwell0");
        check("s5_d0_last", {4'h0, bus.Anode}, 8'h0E);
        run_edge("s5_d1");
        check("s5_d1_anode", {4'h0, bus.Anode}, 8'h0D);

        // 6: leading zeros D3..D0 = 0,0,5,0
        bus.Digit0 = 4'd0;
        bus.Digit1 = 4'd5;
        bus.Digit2 = 4'd0;
        bus.Digit3 = 4'd0;
        bus.DP_in  = 4'b1111;
        while ((k / 4) % 4 != 0) run_edge("s6_wait");
        for (int i = 0; i < 16; i++) run_edge("s6_lz");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
